// File: rtl/laser_feed_pkg.sv
// Shared types and constants for the LASER target feeder.
// Frame geometry and watchdog defaults, FSM state encoding and the
// layout of the packed result word returned to the host.
package laser_feed_pkg;

    // Default frame geometry and watchdog limit
    localparam int N_OBJ_DEF       = 40;
    localparam int COORD_W_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 65535;

    // Feeder sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        COMPUTE = 2'd2,
        RESULT  = 2'd3
    } state_t;

    // Result word is {C1X, C1Y, C2X, C2Y}; each slot is one coordinate wide
    localparam int RES_SLOT_C1X = 3;
    localparam int RES_SLOT_C1Y = 2;
    localparam int RES_SLOT_C2X = 1;
    localparam int RES_SLOT_C2Y = 0;

    // Result word reported when the watchdog expires
    localparam logic [4*COORD_W_DEF-1:0] RES_TIMEOUT_CODE = 16'hFFFF;

endpackage

// File: rtl/laser_frame_bank.sv
// One frame buffer for the LASER feeder: DEPTH x WIDTH register file with
// a single write port, a combinational read port and a full flag that the
// writer sets on the last point and the reader clears once streamed.
module laser_frame_bank
    import laser_feed_pkg::*;
#(
    parameter int DEPTH = N_OBJ_DEF,
    parameter int WIDTH = 2 * COORD_W_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             set_full,
    input  logic             clr_full,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             full_reg;

    // Point storage; contents are don't-care until the full flag says otherwise
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Full flag: set by the last write of a frame, cleared after streaming
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full_reg <= 1'b0;
        end else if (set_full) begin
            full_reg <= 1'b1;
        end else if (clr_full) begin
            full_reg <= 1'b0;
        end
    end

    assign rd_data = mem_reg[rd_addr];
    assign full    = full_reg;

endmodule

// File: rtl/laser_target_feeder.sv
// LASER target feeder: buffers a frame of host points, streams it into the
// LASER core while releasing its reset, then captures the two circle
// centres on DONE (or a watchdog expiry) and returns them to the host.
// Build option LASER_FEED_PINGPONG_EN: two frame banks so the host can load
// the next frame while the current one is streamed/computed/returned.
// Without it a single bank is used and input is only accepted in IDLE.
module laser_target_feeder
    import laser_feed_pkg::*;
#(
    parameter int N_OBJ       = N_OBJ_DEF,
    parameter int COORD_W     = COORD_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [COORD_W-1:0]   IN_X,
    input  logic [COORD_W-1:0]   IN_Y,
    output logic                 LASER_RST,
    output logic [COORD_W-1:0]   LASER_X,
    output logic [COORD_W-1:0]   LASER_Y,
    input  logic                 LASER_DONE,
    input  logic [COORD_W-1:0]   LASER_C1X,
    input  logic [COORD_W-1:0]   LASER_C1Y,
    input  logic [COORD_W-1:0]   LASER_C2X,
    input  logic [COORD_W-1:0]   LASER_C2Y,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [4*COORD_W-1:0] RES_DATA,
    output logic                 TIMEOUT_ERR,
    output logic                 BUSY
);

    localparam int PW    = $clog2(N_OBJ);
    localparam int PT_W  = 2 * COORD_W;
    localparam int RES_W = 4 * COORD_W;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0]   LAST_PTR = PW'(N_OBJ - 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

`ifdef LASER_FEED_PINGPONG_EN
    localparam int NB = 2;
    logic wr_bank_reg;
    logic rd_bank_reg, rd_bank_next;
`else
    localparam int NB = 1;
`endif

    // FSM and datapath registers
    state_t             state_reg, state_next;
    logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]      wr_ptr_reg;
    logic [WD_W-1:0]    wd_cnt_reg, wd_cnt_next;
    logic               laser_rst_reg, laser_rst_next;
    logic [COORD_W-1:0] laser_x_reg, laser_x_next;
    logic [COORD_W-1:0] laser_y_reg, laser_y_next;
    logic               res_valid_reg, res_valid_next;
    logic [RES_W-1:0]   res_data_reg, res_data_next;
    logic               timeout_err_reg, timeout_err_next;
    logic               ready_en_reg;

    // Bank plumbing
    logic [NB-1:0]      bank_full;
    logic [NB-1:0]      bank_wr_sel;
    logic [NB-1:0]      bank_rd_sel;
    logic [PT_W-1:0]    bank_rd_data [NB];
    logic               wr_full;
    logic               rd_full;
    logic [PT_W-1:0]    rd_point;
    logic [PW-1:0]      rd_addr;
    logic               accept;
    logic               wr_last;
    logic               stream_last;

`ifdef LASER_FEED_PINGPONG_EN
    assign bank_wr_sel = wr_bank_reg ? 2'b10 : 2'b01;
    assign bank_rd_sel = rd_bank_reg ? 2'b10 : 2'b01;
    assign wr_full     = bank_full[wr_bank_reg];
    assign rd_full     = bank_full[rd_bank_reg];
    assign rd_point    = bank_rd_data[rd_bank_reg];
    assign IN_READY    = ready_en_reg && !wr_full;
`else
    assign bank_wr_sel = 1'b1;
    assign bank_rd_sel = 1'b1;
    assign wr_full     = bank_full[0];
    assign rd_full     = bank_full[0];
    assign rd_point    = bank_rd_data[0];
    // The single bank is freed at the end of STREAM, but the host must wait
    // for IDLE so it cannot overwrite a frame the core may still be using.
    assign IN_READY    = ready_en_reg && !wr_full && (state_reg == IDLE);
`endif

    assign accept      = IN_VALID && IN_READY;
    assign wr_last     = (wr_ptr_reg == LAST_PTR);
    assign stream_last = (state_reg == STREAM) && (rd_ptr_reg == LAST_PTR);
    // Read one point ahead so the registered LASER_X/Y show point i in cycle i
    assign rd_addr     = ((state_reg == STREAM) && !stream_last) ? rd_ptr_reg + PW'(1) : '0;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bank
            laser_frame_bank #(
                .DEPTH (N_OBJ),
                .WIDTH (PT_W)
            ) u_bank (
                .CLK      (CLK),
                .RST_N    (RST_N),
                .wr_en    (accept && bank_wr_sel[gi]),
                .wr_addr  (wr_ptr_reg),
                .wr_data  ({IN_X, IN_Y}),
                .set_full (accept && bank_wr_sel[gi] && wr_last),
                .clr_full (stream_last && bank_rd_sel[gi]),
                .rd_addr  (rd_addr),
                .rd_data  (bank_rd_data[gi]),
                .full     (bank_full[gi])
            );
        end
    endgenerate

    // Holds IN_READY low while reset is asserted and for the first edge after
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    // Write pointer advances on each accepted point and wraps at frame end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_reg <= '0;
`ifdef LASER_FEED_PINGPONG_EN
            wr_bank_reg <= 1'b0;
`endif
        end else if (accept) begin
            if (wr_last) begin
                wr_ptr_reg <= '0;
`ifdef LASER_FEED_PINGPONG_EN
                wr_bank_reg <= ~wr_bank_reg;
`endif
            end else begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Registered outputs and sequencing counters
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr_reg      <= '0;
            wd_cnt_reg      <= '0;
            laser_rst_reg   <= 1'b1;
            laser_x_reg     <= '0;
            laser_y_reg     <= '0;
            res_valid_reg   <= 1'b0;
            res_data_reg    <= '0;
            timeout_err_reg <= 1'b0;
`ifdef LASER_FEED_PINGPONG_EN
            rd_bank_reg     <= 1'b0;
`endif
        end else begin
            rd_ptr_reg      <= rd_ptr_next;
            wd_cnt_reg      <= wd_cnt_next;
            laser_rst_reg   <= laser_rst_next;
            laser_x_reg     <= laser_x_next;
            laser_y_reg     <= laser_y_next;
            res_valid_reg   <= res_valid_next;
            res_data_reg    <= res_data_next;
            timeout_err_reg <= timeout_err_next;
`ifdef LASER_FEED_PINGPONG_EN
            rd_bank_reg     <= rd_bank_next;
`endif
        end
    end

    // Next-state and next-output logic for the feed/compute/result sequence
    always_comb begin
        state_next       = state_reg;
        rd_ptr_next      = rd_ptr_reg;
        wd_cnt_next      = wd_cnt_reg;
        laser_rst_next   = laser_rst_reg;
        laser_x_next     = laser_x_reg;
        laser_y_next     = laser_y_reg;
        res_valid_next   = res_valid_reg;
        res_data_next    = res_data_reg;
        timeout_err_next = timeout_err_reg;
`ifdef LASER_FEED_PINGPONG_EN
        rd_bank_next     = rd_bank_reg;
`endif
        case (state_reg)
            IDLE: begin
                laser_rst_next = 1'b1;
                if (rd_full) begin
                    // Release LASER together with presenting point 0
                    state_next     = STREAM;
                    rd_ptr_next    = '0;
                    laser_rst_next = 1'b0;
                    laser_x_next   = rd_point[PT_W-1:COORD_W];
                    laser_y_next   = rd_point[COORD_W-1:0];
                end
            end
            STREAM: begin
                laser_rst_next = 1'b0;
                if (stream_last) begin
                    state_next  = COMPUTE;
                    rd_ptr_next = '0;
                    wd_cnt_next = '0;
`ifdef LASER_FEED_PINGPONG_EN
                    rd_bank_next = ~rd_bank_reg;
`endif
                end else begin
                    rd_ptr_next  = rd_ptr_reg + PW'(1);
                    laser_x_next = rd_point[PT_W-1:COORD_W];
                    laser_y_next = rd_point[COORD_W-1:0];
                end
            end
            COMPUTE: begin
                laser_rst_next = 1'b0;
                if (LASER_DONE) begin
                    res_data_next[RES_SLOT_C1X*COORD_W +: COORD_W] = LASER_C1X;
                    res_data_next[RES_SLOT_C1Y*COORD_W +: COORD_W] = LASER_C1Y;
                    res_data_next[RES_SLOT_C2X*COORD_W +: COORD_W] = LASER_C2X;
                    res_data_next[RES_SLOT_C2Y*COORD_W +: COORD_W] = LASER_C2Y;
                    res_valid_next = 1'b1;
                    laser_rst_next = 1'b1;
                    state_next     = RESULT;
                end else if (wd_cnt_reg == WD_LAST) begin
                    // The timeout code is still handed to the host as a result
                    // so the host handshake completes and the feeder recovers.
                    res_data_next    = RES_W'(RES_TIMEOUT_CODE);
                    res_valid_next   = 1'b1;
                    timeout_err_next = 1'b1;
                    laser_rst_next   = 1'b1;
                    state_next       = RESULT;
                end else begin
                    wd_cnt_next = wd_cnt_reg + WD_W'(1);
                end
            end
            RESULT: begin
                laser_rst_next = 1'b1;
                if (RES_READY) begin
                    res_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign LASER_RST   = laser_rst_reg;
    assign LASER_X     = laser_x_reg;
    assign LASER_Y     = laser_y_reg;
    assign RES_VALID   = res_valid_reg;
    assign RES_DATA    = res_data_reg;
    assign TIMEOUT_ERR = timeout_err_reg;
    assign BUSY        = (state_reg != IDLE);

endmodule

// File: tb/tb_laser_target_feeder.sv
// Directed bench for laser_target_feeder (watchdog shortened to 100 cycles).
module tb_laser_target_feeder;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [3:0]  IN_X, IN_Y;
    logic        LASER_RST;
    logic [3:0]  LASER_X, LASER_Y;
    logic        LASER_DONE;
    logic [3:0]  LASER_C1X, LASER_C1Y, LASER_C2X, LASER_C2Y;
    logic        RES_VALID;
    logic        RES_READY;
    logic [15:0] RES_DATA;
    logic        TIMEOUT_ERR;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    laser_target_feeder #(
        .N_OBJ       (40),
        .COORD_W     (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_X        (IN_X),
        .IN_Y        (IN_Y),
        .LASER_RST   (LASER_RST),
        .LASER_X     (LASER_X),
        .LASER_Y     (LASER_Y),
        .LASER_DONE  (LASER_DONE),
        .LASER_C1X   (LASER_C1X),
        .LASER_C1Y   (LASER_C1Y),
        .LASER_C2X   (LASER_C2X),
        .LASER_C2Y   (LASER_C2Y),
        .RES_VALID   (RES_VALID),
        .RES_READY   (RES_READY),
        .RES_DATA    (RES_DATA),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .BUSY        (BUSY)
    );

    // Frame point pattern; seed 0 gives X=i%16, Y=i/16
    function automatic logic [3:0] pt_x(input int seed, input int i);
        return 4'((i + seed) % 16);
    endfunction

    function automatic logic [3:0] pt_y(input int seed, input int i);
        return 4'(((i / 16) + 2 * seed) % 16);
    endfunction

    // Offer points first..first+count-1; optionally valid only every other cycle
    task automatic load_frame(input int seed, input bit toggle, input int first, input int count);
        int i;
        int cyc;
        i = first;
        cyc = 0;
        while (i < first + count && cyc < 400) begin
            IN_VALID = (!toggle || (cyc % 2 == 0));
            IN_X = pt_x(seed, i);
            IN_Y = pt_y(seed, i);
            checks++;
            if (IN_READY !== 1'b1) begin
                errors++;
                $display("FAIL load_ready: seed %0d point %0d IN_READY=%b expected 1", seed, i, IN_READY);
            end
            if (IN_VALID && IN_READY) i++;
            cyc++;
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        checks++;
        if (i != first + count) begin
            errors++;
            $display("FAIL load_bound: seed %0d accepted up to %0d expected %0d", seed, i, first + count);
        end
        $display("load seed %0d points %0d..%0d in %0d cycles", seed, first, i - 1, cyc);
    endtask

    // Called at the negedge after the frame-filling edge; ends in COMPUTE
    task automatic stream_frame(input int seed);
        checks++;
        if (LASER_RST !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL stream_pre: LASER_RST=%b BUSY=%b expected 1 0", LASER_RST, BUSY);
        end
`ifndef LASER_FEED_PINGPONG_EN
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL stream_pre_ready: IN_READY=%b expected 0", IN_READY);
        end
`endif
        @(negedge CLK);
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (LASER_RST !== 1'b0 || BUSY !== 1'b1 || {LASER_X, LASER_Y} !== {pt_x(seed, k), pt_y(seed, k)}) begin
                errors++;
                $display("FAIL stream_pt: seed %0d cycle %0d got rst=%b busy=%b xy=%h expected 0 1 %h",
                         seed, k, LASER_RST, BUSY, {LASER_X, LASER_Y}, {pt_x(seed, k), pt_y(seed, k)});
            end
`ifndef LASER_FEED_PINGPONG_EN
            checks++;
            if (IN_READY !== 1'b0) begin
                errors++;
                $display("FAIL stream_ready: cycle %0d IN_READY=%b expected 0", k, IN_READY);
            end
`endif
            @(negedge CLK);
        end
        $display("stream seed %0d 40 points", seed);
    endtask

    // One-cycle DONE pulse from the behavioural LASER model
    task automatic deliver_done(input logic [3:0] c1x, input logic [3:0] c1y,
                                input logic [3:0] c2x, input logic [3:0] c2y);
        LASER_DONE = 1'b1;
        LASER_C1X = c1x; LASER_C1Y = c1y; LASER_C2X = c2x; LASER_C2Y = c2y;
        @(negedge CLK);
        LASER_DONE = 1'b0;
        LASER_C1X = '0; LASER_C1Y = '0; LASER_C2X = '0; LASER_C2Y = '0;
    endtask

    task automatic accept_result();
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        IN_VALID = 1'b0; IN_X = '0; IN_Y = '0;
        LASER_DONE = 1'b0;
        LASER_C1X = '0; LASER_C1Y = '0; LASER_C2X = '0; LASER_C2Y = '0;
        RES_READY = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({LASER_RST, LASER_X, LASER_Y, RES_VALID, RES_DATA, TIMEOUT_ERR, BUSY, IN_READY} !==
            {1'b1, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_vals: rst=%b x=%h y=%h rv=%b rd=%h to=%b busy=%b rdy=%b expected 1 0 0 0 0000 0 0 0",
                     LASER_RST, LASER_X, LASER_Y, RES_VALID, RES_DATA, TIMEOUT_ERR, BUSY, IN_READY);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: IN_READY=%b BUSY=%b expected 1 0", IN_READY, BUSY);
        end
        $display("reset done");
    endtask

    task automatic test_frame_stream();
        load_frame(0, 1'b0, 0, 40);
        stream_frame(0);
        checks++;
        if (LASER_RST !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL compute_entry: LASER_RST=%b BUSY=%b expected 0 1", LASER_RST, BUSY);
        end
    endtask

    task automatic test_result_handshake();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (RES_VALID !== 1'b0 || LASER_RST !== 1'b0) begin
                errors++;
                $display("FAIL compute_wait: cycle %0d RES_VALID=%b LASER_RST=%b expected 0 0", k, RES_VALID, LASER_RST);
            end
            @(negedge CLK);
        end
        deliver_done(4'd3, 4'd4, 4'd11, 4'd9);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (RES_VALID !== 1'b1 || RES_DATA !== 16'h34B9 || LASER_RST !== 1'b1 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL result_hold: cycle %0d rv=%b data=%h rst=%b busy=%b expected 1 34b9 1 1",
                         k, RES_VALID, RES_DATA, LASER_RST, BUSY);
            end
            if (k < 5) @(negedge CLK);
        end
        accept_result();
        checks++;
        if (RES_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL result_drop: RES_VALID=%b BUSY=%b expected 0 0", RES_VALID, BUSY);
        end
        $display("result %h accepted", 16'h34B9);
        // DONE while idle must not produce a result
        deliver_done(4'd1, 4'd1, 4'd1, 4'd1);
        @(negedge CLK);
        checks++;
        if (RES_VALID !== 1'b0 || BUSY !== 1'b0 || RES_DATA !== 16'h34B9) begin
            errors++;
            $display("FAIL done_idle: rv=%b busy=%b data=%h expected 0 0 34b9", RES_VALID, BUSY, RES_DATA);
        end
    endtask

    task automatic test_pingpong();
        load_frame(1, 1'b0, 0, 40);
        stream_frame(1);
`ifdef LASER_FEED_PINGPONG_EN
        // Next frame loads while frame 1 is computing
        load_frame(2, 1'b0, 0, 40);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (BUSY !== 1'b1 || RES_VALID !== 1'b0 || LASER_RST !== 1'b0) begin
                errors++;
                $display("FAIL pp_compute: busy=%b rv=%b rst=%b expected 1 0 0", BUSY, RES_VALID, LASER_RST);
            end
            @(negedge CLK);
        end
        deliver_done(4'd5, 4'd6, 4'd7, 4'd8);
        checks++;
        if (RES_VALID !== 1'b1 || RES_DATA !== 16'h5678) begin
            errors++;
            $display("FAIL pp_result1: rv=%b data=%h expected 1 5678", RES_VALID, RES_DATA);
        end
        accept_result();
        stream_frame(2);
        deliver_done(4'd9, 4'd10, 4'd11, 4'd12);
        checks++;
        if (RES_VALID !== 1'b1 || RES_DATA !== 16'h9ABC) begin
            errors++;
            $display("FAIL pp_result2: rv=%b data=%h expected 1 9abc", RES_VALID, RES_DATA);
        end
        accept_result();
        $display("pingpong frames 1 and 2 done");
`else
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (IN_READY !== 1'b0 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL sb_compute_ready: IN_READY=%b BUSY=%b expected 0 1", IN_READY, BUSY);
            end
            @(negedge CLK);
        end
        deliver_done(4'd5, 4'd6, 4'd7, 4'd8);
        checks++;
        if (IN_READY !== 1'b0 || RES_DATA !== 16'h5678 || RES_VALID !== 1'b1) begin
            errors++;
            $display("FAIL sb_result_ready: rdy=%b data=%h rv=%b expected 0 5678 1", IN_READY, RES_DATA, RES_VALID);
        end
        accept_result();
        checks++;
        if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL sb_idle_ready: IN_READY=%b BUSY=%b expected 1 0", IN_READY, BUSY);
        end
        $display("single-bank frame 1 done");
`endif
    endtask

    task automatic test_timeout();
        load_frame(3, 1'b0, 0, 40);
        stream_frame(3);
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            if (k == 99) begin
                checks++;
                if (RES_VALID !== 1'b0 || TIMEOUT_ERR !== 1'b0 || LASER_RST !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_early: rv=%b to=%b rst=%b expected 0 0 0", RES_VALID, TIMEOUT_ERR, LASER_RST);
                end
            end
        end
        checks++;
        if (RES_VALID !== 1'b1 || RES_DATA !== 16'hFFFF || TIMEOUT_ERR !== 1'b1 || LASER_RST !== 1'b1) begin
            errors++;
            $display("FAIL wd_fire: rv=%b data=%h to=%b rst=%b expected 1 ffff 1 1",
                     RES_VALID, RES_DATA, TIMEOUT_ERR, LASER_RST);
        end
        accept_result();
        $display("timeout result accepted");
        load_frame(4, 1'b0, 0, 40);
        stream_frame(4);
        deliver_done(4'd1, 4'd2, 4'd13, 4'd14);
        checks++;
        if (RES_VALID !== 1'b1 || RES_DATA !== 16'h12DE || TIMEOUT_ERR !== 1'b1) begin
            errors++;
            $display("FAIL wd_sticky: rv=%b data=%h to=%b expected 1 12de 1", RES_VALID, RES_DATA, TIMEOUT_ERR);
        end
        accept_result();
    endtask

    task automatic test_reset_mid_stream();
        load_frame(5, 1'b0, 0, 40);
        @(negedge CLK);
        repeat (17) @(negedge CLK);
        checks++;
        if ({LASER_X, LASER_Y} !== {pt_x(5, 17), pt_y(5, 17)} || LASER_RST !== 1'b0) begin
            errors++;
            $display("FAIL mid_point17: xy=%h rst=%b expected %h 0", {LASER_X, LASER_Y}, LASER_RST, {pt_x(5, 17), pt_y(5, 17)});
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if (LASER_RST !== 1'b1 || RES_VALID !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rst=%b rv=%b busy=%b rdy=%b to=%b expected 1 0 0 0 0",
                     LASER_RST, RES_VALID, BUSY, IN_READY, TIMEOUT_ERR);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        load_frame(6, 1'b0, 0, 39);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (BUSY !== 1'b0 || LASER_RST !== 1'b1) begin
                errors++;
                $display("FAIL mid_partial: cycle %0d busy=%b rst=%b expected 0 1", k, BUSY, LASER_RST);
            end
            @(negedge CLK);
        end
        load_frame(6, 1'b0, 39, 1);
        stream_frame(6);
        deliver_done(4'd2, 4'd3, 4'd4, 4'd5);
        checks++;
        if (RES_VALID !== 1'b1 || RES_DATA !== 16'h2345) begin
            errors++;
            $display("FAIL mid_result: rv=%b data=%h expected 1 2345", RES_VALID, RES_DATA);
        end
        accept_result();
    endtask

    task automatic test_toggle_valid();
        load_frame(7, 1'b1, 0, 40);
        stream_frame(7);
        deliver_done(4'd15, 4'd0, 4'd0, 4'd15);
        checks++;
        if (RES_VALID !== 1'b1 || RES_DATA !== 16'hF00F) begin
            errors++;
            $display("FAIL toggle_result: rv=%b data=%h expected 1 f00f", RES_VALID, RES_DATA);
        end
        accept_result();
        checks++;
        if (RES_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL toggle_idle: rv=%b busy=%b expected 0 0", RES_VALID, BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_frame_stream();
        test_result_handshake();
        test_pingpong();
        test_timeout();
        test_reset_mid_stream();
        test_toggle_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
